instr_fetch: RTL and testbench

- Fetch stage of the RV32 core; sits directly upstream of the decode/immediate logic.
- Generates sequential PCs, issues word requests to instruction memory, and buffers returned instructions in a small in-order queue.
- Presents the queue head to decode as instr/opcode/funct3/pc with a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the queue and discarding in-flight responses.

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// RV32 fetch: in-order word requests, DEPTH-entry decode queue (response -> dec_valid next cycle), redirect flushes via a kill counter.
// Requests stall while queued + outstanding reach DEPTH. Define FETCH_MISALIGN_EN to add the fetch_misalign output.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter int              OP_LEN   = 7,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [XLEN-1:0]   instr,
  output logic [OP_LEN-1:0] opcode,
  output logic [2:0]        funct3,
`ifdef FETCH_MISALIGN_EN
  output logic              fetch_misalign,
`endif
  output logic [XLEN-1:0]   pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   osd;
  logic [CW-1:0]   kill;
  entry_t          q [DEPTH];
  logic [XLEN-1:0] oa [DEPTH];

  logic          req_fire;
  logic          rsp_hit;
  logic          pop;
  logic [CW-1:0] kill_src;
  logic [CW-1:0] kill_next;
  logic [IW-1:0] q_wr;
  logic [IW-1:0] oa_wr;

  assign imem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                          (({1'b0, osd} + {1'b0, cnt}) < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_hit   = imem_rsp_valid && (state == RUN) && (osd != '0);
  assign dec_valid = !rst && (cnt != '0);
  assign pop       = dec_valid && dec_ready;

  // Responses still owed at a redirect: outstanding in RUN, the running kill count in FLUSH.
  assign kill_src  = (state == FLUSH) ? kill : osd;
  assign kill_next = kill_src - CW'(imem_rsp_valid && (kill_src != '0));

  assign q_wr  = IW'(cnt - CW'(pop));
  assign oa_wr = IW'(osd - CW'(rsp_hit));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      cnt      <= '0;
      osd      <= '0;
      kill     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i]  <= '{instr: NOP, pc: RESET_PC};
        oa[i] <= RESET_PC;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      cnt      <= '0;
      osd      <= '0;
      kill     <= kill_next;
      state    <= (kill_next != '0) ? FLUSH : RUN;
    end else if (state == FLUSH) begin
      kill <= kill_next;
      if (kill_next == '0) state <= RUN;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      osd <= osd + CW'(req_fire) - CW'(rsp_hit);
      cnt <= cnt + CW'(rsp_hit) - CW'(pop);
      if (rsp_hit) begin
        for (int i = 0; i < DEPTH - 1; i++) oa[i] <= oa[i+1];
      end
      if (req_fire) oa[oa_wr] <= fetch_pc;
      // Last popped entry stays in q[0] so the head outputs hold while empty.
      if (pop && (cnt > CW'(1))) begin
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      end
      if (rsp_hit) q[q_wr] <= '{instr: imem_rdata, pc: oa[0]};
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) fetch_misalign <= 1'b0;
    else     fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^redirect_pc[1:0];
`endif

  assign instr  = q[0].instr;
  assign opcode = q[0].instr[OP_LEN-1:0];
  assign funct3 = q[0].instr[14:12];
  assign pc     = q[0].pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed steps plus a random phase, decode outputs checked against an expected-entry queue.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  int          total = 0;
  int          bad   = 0;
  int          fires = 0;
  bit          rsp_en = 1'b0;
  bit          flush_on_rst = 1'b1;
  logic [31:0] pend [$];
  ent_t        exp_dec [$];
  logic [31:0] exp_pc = 32'h0;
  ent_t        e;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .instr          (instr),
    .opcode         (opcode),
    .funct3         (funct3),
`ifdef FETCH_MISALIGN_EN
    .fetch_misalign (fetch_misalign),
`endif
    .pc             (pc)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[21:2], a[6:4], 5'h0, 4'h3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic den, input bit ren);
    rst = 1'b1; redirect_valid = 1'b0;
    imem_req_ready = rdy; dec_ready = den; rsp_en = ren;
    cyc(2);
    rst = 1'b0; fires = 0;
  endtask

  task automatic drain();
    imem_req_ready = 1'b0; redirect_valid = 1'b0; rsp_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 40 && exp_dec.size() != 0; i++) cyc(1);
    chk("drain", 32'(exp_dec.size()), 32'd0);
  endtask

  // Instruction memory: in-order, one cycle after the request at the earliest.
  always @(posedge clk) begin
    #2;
    if (rst && flush_on_rst) pend.delete();
    if (rsp_en && !rst && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = memf(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = 32'h0;
    end
  end

  // Request address model and decode scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_dec.delete();
      exp_pc = 32'h0;
    end else if (redirect_valid) begin
      exp_dec.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, exp_pc);
        pend.push_back(imem_addr);
        exp_dec.push_back('{instr: memf(exp_pc), pc: exp_pc});
        exp_pc = exp_pc + 32'd4;
        fires++;
      end
      if (dec_valid && dec_ready) begin
        if (exp_dec.size() == 0) begin
          chk("dec_extra", 32'(dec_valid), 32'd0);
        end else begin
          e = exp_dec.pop_front();
          chk("dec_instr", instr, e.instr);
          chk("dec_pc", pc, e.pc);
          chk("dec_opcode", 32'(opcode), 32'(e.instr[6:0]));
          chk("dec_funct3", 32'(funct3), 32'(e.instr[14:12]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; imem_req_ready = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset values, then streaming from RESET_PC.
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_opcode", 32'(opcode), 32'h13);
    chk("rst_funct3", 32'(funct3), 32'd0);
    chk("rst_pc", pc, 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    cyc(1);
    rst = 1'b0; imem_req_ready = 1'b1; rsp_en = 1'b1; dec_ready = 1'b1; fires = 0;
    @(negedge clk);
    chk("s_req0_valid", 32'(imem_req_valid), 32'd1);
    chk("s_req0_addr", imem_addr, 32'h0);
    chk("s_c0_dec", 32'(dec_valid), 32'd0);
    @(negedge clk);
    chk("s_c1_dec", 32'(dec_valid), 32'd0);
    @(negedge clk);
    chk("s_c2_dec", 32'(dec_valid), 32'd1);
    chk("s_c2_instr", instr, 32'h0050_0093);
    chk("s_c2_pc", pc, 32'h0);
    @(negedge clk);
    chk("s_c3_instr", instr, 32'h00A0_0113);
    chk("s_c3_pc", pc, 32'h4);
    cyc(4);
    drain();

    // Decode backpressure fills the budget with two requests.
    do_reset(1'b1, 1'b0, 1'b1);
    cyc(8);
    chk("bp_fires", 32'(fires), 32'd2);
    @(negedge clk);
    chk("bp_stall", 32'(imem_req_valid), 32'd0);
    cyc(1); dec_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_cycle", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("bp_resume", 32'(imem_req_valid), 32'd1);
    chk("bp_addr", imem_addr, 32'h8);
    cyc(1);
    drain();

    // Redirect with two requests outstanding.
    do_reset(1'b1, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("fl_full", 32'(imem_req_valid), 32'd0);
    cyc(1); redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("fl_redir_noreq", 32'(imem_req_valid), 32'd0);
    cyc(1); redirect_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("fl_noreq", 32'(imem_req_valid), 32'd0);
      chk("fl_nodec", 32'(dec_valid), 32'd0);
    end
    cyc(1); rsp_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("fl_drop_dec", 32'(dec_valid), 32'd0);
    end while (!imem_req_valid && n < 10);
    chk("fl_len", 32'(n), 32'd3);
    chk("fl_addr", imem_addr, 32'h100);
    cyc(5);
    drain();

    // Misaligned redirect with nothing outstanding.
    do_reset(1'b0, 1'b1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    chk("mis_redir_noreq", 32'(imem_req_valid), 32'd0);
    cyc(1); redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_req", 32'(imem_req_valid), 32'd1);
    chk("mis_addr", imem_addr, 32'h100);
`ifdef FETCH_MISALIGN_EN
    chk("mis_flag_hi", 32'(fetch_misalign), 32'd1);
`endif
    @(negedge clk);
    chk("mis_run", 32'(imem_req_valid), 32'd1);
`ifdef FETCH_MISALIGN_EN
    chk("mis_flag_lo", 32'(fetch_misalign), 32'd0);
`endif
    cyc(1); imem_req_ready = 1'b1;
    cyc(5);
    drain();

    // Redirect landing together with a response and a pop: nothing left to kill.
    do_reset(1'b1, 1'b1, 1'b1);
    cyc(6);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("co_dec_busy", 32'(dec_valid), 32'd1);
    cyc(1); redirect_valid = 1'b0;
    @(negedge clk);
    chk("co_req", 32'(imem_req_valid), 32'd1);
    chk("co_addr", imem_addr, 32'h200);
    chk("co_dec_empty", 32'(dec_valid), 32'd0);
    cyc(5);
    drain();

    // Budget full (one queued, one outstanding): push and pop in one cycle.
    do_reset(1'b1, 1'b0, 1'b1);
    cyc(5);
    rsp_en = 1'b0; dec_ready = 1'b1;
    cyc(1); dec_ready = 1'b0;
    @(negedge clk);
    chk("pp_fire", 32'(imem_req_valid), 32'd1);
    chk("pp_fire_addr", imem_addr, 32'h8);
    cyc(1);
    @(negedge clk);
    chk("pp_full_noreq", 32'(imem_req_valid), 32'd0);
    chk("pp_head4", pc, 32'h4);
    cyc(1); rsp_en = 1'b1; dec_ready = 1'b1;
    @(negedge clk);
    chk("pp_both_dec", 32'(dec_valid), 32'd1);
    chk("pp_both_noreq", 32'(imem_req_valid), 32'd0);
    cyc(1); dec_ready = 1'b0;
    @(negedge clk);
    chk("pp_after_dec", 32'(dec_valid), 32'd1);
    chk("pp_after_pc", pc, 32'h8);
    chk("pp_after_instr", instr, memf(32'h8));
    chk("pp_after_req", 32'(imem_req_valid), 32'd1);
    cyc(1);
    drain();

    // Reset while flushing with kill = 2; the late responses must vanish.
    do_reset(1'b1, 1'b1, 1'b0);
    cyc(3);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc(1); redirect_valid = 1'b0;
    cyc(1); flush_on_rst = 1'b0; rst = 1'b1; imem_req_ready = 1'b0;
    cyc(1); rst = 1'b0;
    @(negedge clk);
    chk("rf_req", 32'(imem_req_valid), 32'd1);
    chk("rf_addr", imem_addr, 32'h0);
    chk("rf_dec", 32'(dec_valid), 32'd0);
    cyc(1); rsp_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rf_late_dec", 32'(dec_valid), 32'd0);
    end
    cyc(1); flush_on_rst = 1'b1; imem_req_ready = 1'b1;
    cyc(6);
    drain();

    // Random traffic with occasional redirects, including one near the address wrap.
    do_reset(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      rsp_en         = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF2 : 32'($urandom);
      cyc(1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
